// File: rtl/l2_request_scheduler_pkg.sv
// Shared L2 request types and machine-wide sizing defines for the request scheduler.
// The packet is the unit that enters the first L2 pipeline stage.
`ifndef NUM_CORES
`define NUM_CORES 4
`endif
`ifndef CACHE_LINE_BITS
`define CACHE_LINE_BITS 512
`endif

package l2_request_scheduler_pkg;
  localparam int CORE_ID_BITS = (`NUM_CORES > 1) ? $clog2(`NUM_CORES) : 1;
  localparam int ADDR_BITS    = 32;

  typedef struct packed {
    logic                    valid;
    logic [CORE_ID_BITS-1:0] core;
    logic                    store;
    logic [ADDR_BITS-1:0]    address;
  } l2req_packet_t;
endpackage

// File: rtl/l2_request_scheduler_if.sv
// Request/restart inputs and the registered pipeline-entry outputs of the L2 scheduler.
// The master side drives requests; the slave side is the scheduler.
interface l2_request_scheduler_if #(
  parameter int NUM_REQUESTERS = `NUM_CORES
);
  import l2_request_scheduler_pkg::*;

  localparam int IDX_BITS = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  l2req_packet_t [NUM_REQUESTERS-1:0] core_l2req_packet;
  logic [NUM_REQUESTERS-1:0]          core_l2req_ready;
  l2req_packet_t                      smi_restart_packet;
  logic [`CACHE_LINE_BITS-1:0]        smi_restart_data;
  logic                               smi_restart_ready;
  logic                               pipeline_stall;
  l2req_packet_t                      arb_l2req_packet;
  logic                               arb_is_restart;
  logic [`CACHE_LINE_BITS-1:0]        arb_data;
  logic [IDX_BITS-1:0]                arb_grant_index;

  modport master (
    output core_l2req_packet, smi_restart_packet, smi_restart_data, pipeline_stall,
    input  core_l2req_ready, smi_restart_ready, arb_l2req_packet, arb_is_restart,
    input  arb_data, arb_grant_index
  );

  modport slave (
    input  core_l2req_packet, smi_restart_packet, smi_restart_data, pipeline_stall,
    output core_l2req_ready, smi_restart_ready, arb_l2req_packet, arb_is_restart,
    output arb_data, arb_grant_index
  );
endinterface

// File: rtl/l2_request_scheduler_rr_picker.sv
// Combinational round-robin picker: searches upward from ptr+1 with wrap and
// returns a one-hot grant plus its index. Width-generic for reuse in other arbiters.
module l2_rr_picker #(
  parameter int WIDTH    = 4,
  parameter int IDX_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]    req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic [WIDTH-1:0]    gnt,
  output logic [IDX_BITS-1:0] idx,
  output logic                any
);
  int                  raw;
  int                  pos;
  logic [IDX_BITS-1:0] cand;
  logic                hit;
  logic                found;

  // First requester found after ptr wins; later hits are masked by found.
  always_comb begin
    gnt   = {WIDTH{1'b0}};
    idx   = {IDX_BITS{1'b0}};
    found = 1'b0;
    raw   = 32'sd0;
    pos   = 32'sd0;
    cand  = {IDX_BITS{1'b0}};
    hit   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      raw       = int'(ptr) + i + 32'sd1;
      pos       = (raw >= WIDTH) ? raw - WIDTH : raw;
      cand      = IDX_BITS'(pos);
      hit       = ~found & req[cand];
      gnt[cand] = gnt[cand] | hit;
      idx       = hit ? cand : idx;
      found     = found | hit;
    end
  end

  assign any = |req;
endmodule

// File: rtl/l2_request_scheduler.sv
// Admission scheduler for the single L2 pipeline entry slot: SMI restarts first,
// cores round-robin, with a starvation counter that forces a core grant.
module l2_request_scheduler
  import l2_request_scheduler_pkg::*;
#(
  parameter int NUM_REQUESTERS = `NUM_CORES,
  parameter int STARVE_LIMIT   = 8
) (
  input logic                  clk,
  input logic                  reset,
  l2_request_scheduler_if.slave bus
);
  localparam int IDX_BITS = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int CNT_BITS = $clog2(STARVE_LIMIT + 1);

  logic [NUM_REQUESTERS-1:0]   core_req;
  logic [NUM_REQUESTERS-1:0]   pick_gnt;
  logic [IDX_BITS-1:0]         pick_idx;
  logic                        core_wait;
  logic                        restart_win;
  logic                        core_win;

  logic [IDX_BITS-1:0]         rr_ptr_d, rr_ptr_q;
  logic [CNT_BITS-1:0]         starve_cnt_d, starve_cnt_q;
  l2req_packet_t               arb_pkt_d, arb_pkt_q;
  logic                        is_restart_d, is_restart_q;
  logic [`CACHE_LINE_BITS-1:0] data_d, data_q;
  logic [IDX_BITS-1:0]         grant_idx_d, grant_idx_q;

  // Stall masks core requests only; restarts must keep draining the SMI queue.
  always_comb begin
    core_req = {NUM_REQUESTERS{1'b0}};
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      core_req[i] = bus.core_l2req_packet[i].valid & ~bus.pipeline_stall;
    end
  end

  l2_rr_picker #(.WIDTH(NUM_REQUESTERS), .IDX_BITS(IDX_BITS)) u_picker (
    .req (core_req),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (core_wait)
  );

  assign restart_win = bus.smi_restart_packet.valid &
                       ~(core_wait & (starve_cnt_q == CNT_BITS'(STARVE_LIMIT)));
  assign core_win    = core_wait & ~restart_win;

  assign bus.core_l2req_ready  = (core_win & ~reset) ? pick_gnt : {NUM_REQUESTERS{1'b0}};
  assign bus.smi_restart_ready = restart_win & ~reset;

  // Next pointer, starvation count and the packet to register for the pipeline.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    starve_cnt_d = starve_cnt_q;
    arb_pkt_d    = '0;
    is_restart_d = 1'b0;
    data_d       = {`CACHE_LINE_BITS{1'b0}};
    grant_idx_d  = {IDX_BITS{1'b0}};
    if (core_win || !core_wait) begin
      starve_cnt_d = {CNT_BITS{1'b0}};
    end else if (starve_cnt_q != CNT_BITS'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + CNT_BITS'(1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
    if (restart_win) begin
      arb_pkt_d       = bus.smi_restart_packet;
      arb_pkt_d.valid = 1'b1;
      is_restart_d    = 1'b1;
      data_d          = bus.smi_restart_data;
    end else if (core_win) begin
      rr_ptr_d        = pick_idx;
      arb_pkt_d       = bus.core_l2req_packet[pick_idx];
      arb_pkt_d.valid = 1'b1;
      grant_idx_d     = pick_idx;
    end else begin
      arb_pkt_d = '0;
    end
  end

  // Reset points rr_ptr at the last core so core 0 is searched first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q     <= IDX_BITS'(NUM_REQUESTERS - 1);
      starve_cnt_q <= {CNT_BITS{1'b0}};
      arb_pkt_q    <= '0;
      is_restart_q <= 1'b0;
      data_q       <= {`CACHE_LINE_BITS{1'b0}};
      grant_idx_q  <= {IDX_BITS{1'b0}};
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      arb_pkt_q    <= arb_pkt_d;
      is_restart_q <= is_restart_d;
      data_q       <= data_d;
      grant_idx_q  <= grant_idx_d;
    end
  end

  assign bus.arb_l2req_packet = arb_pkt_q;
  assign bus.arb_is_restart   = is_restart_q;
  assign bus.arb_data         = data_q;
  assign bus.arb_grant_index  = grant_idx_q;
endmodule
